// File: rtl/pe_req_scheduler.sv
// pe_req_scheduler
//   Shares one PE between NUM_REQ requesters. A round-robin arbiter accepts
//   one valid/ready instruction at a time, issues it to the PE as a one-cycle
//   valid pulse, waits for the PE result and returns it to the requester that
//   owns the op as a one-hot, one-cycle response pulse.
//
//   Optional feature macro: PE_SCHED_TIMEOUT_EN
//     defined   : a WAIT that lasts TIMEOUT_CYC cycles is aborted with a
//                 32'hDEAD_BEEF response and a one-cycle err_timeout pulse.
//     undefined : WAIT holds until the PE answers; err_timeout is tied 0.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/instr   per-requester request; requester i at req_instr[32*i +: 32]
//   req_ready         one-hot accept, only ever non-zero in IDLE
//   rsp_valid         one-hot, one-cycle result pulse to the owning requester
//   rsp_data, rsp_id  result data and owner id accompanying rsp_valid
//   pe_instr          instruction to the PE, held from accept until back in IDLE
//   pe_valid_in       one-cycle issue pulse to the PE
//   pe_result(_valid) result from the PE (honoured in ISSUE and WAIT only)
//   busy              high whenever an op is in flight
//   err_timeout       one-cycle abort pulse
module pe_req_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*32-1:0]      req_instr,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [31:0]                rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [31:0]                pe_instr,
    output logic                       pe_valid_in,
    input  logic [31:0]                pe_result,
    input  logic                       pe_result_valid,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int          IDW = $clog2(NUM_REQ);
    localparam int unsigned NR  = NUM_REQ;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]         state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     owner;
    logic [IDW-1:0]     grant_id;
    logic               grant_found;
    logic [NUM_REQ-1:0] grant_oh;
    logic               take;
    logic               res_hit;
    logic               timeout_hit;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (32'(rr_ptr) + k) % NR;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign grant_oh    = grant_found ? (NUM_REQ'(1) << grant_id) : '0;
    assign req_ready   = (state == ST_IDLE) ? grant_oh : '0;
    assign take        = (state == ST_IDLE) && grant_found;
    // A zero-latency PE answers during the ISSUE cycle itself.
    assign res_hit     = pe_result_valid && ((state == ST_ISSUE) || (state == ST_WAIT));
    assign pe_valid_in = (state == ST_ISSUE);
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            pe_instr  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        pe_instr <= req_instr[32*grant_id +: 32];
                        owner    <= grant_id;
                        rr_ptr   <= IDW'((32'(grant_id) + 32'd1) % NR);
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= res_hit ? ST_IDLE : ST_WAIT;
                ST_WAIT: begin
                    if (res_hit || timeout_hit) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A real result takes precedence over a coincident timeout.
            if (res_hit) begin
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_data  <= pe_result;
                rsp_id    <= owner;
            end else if (timeout_hit) begin
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_data  <= 32'hDEAD_BEEF;
                rsp_id    <= owner;
            end
        end
    end

`ifdef PE_SCHED_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [TW-1:0] to_cnt;

    assign timeout_hit = (state == ST_WAIT) && !pe_result_valid &&
                         (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (state == ST_ISSUE)
                to_cnt <= '0;
            else if (state == ST_WAIT)
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pe_req_scheduler.sv
// Self-checking bench for pe_req_scheduler (NUM_REQ=4, TIMEOUT_CYC=8).
// A behavioural PE with programmable latency answers each issue; expected
// responses are queued when a grant is observed and checked on rsp_valid.
module tb_pe_req_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [127:0] req_instr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_id;
    logic [31:0] pe_instr;
    logic        pe_valid_in;
    logic [31:0] pe_result;
    logic        pe_result_valid;
    logic        busy;
    logic        err_timeout;

    always #5 clk = ~clk;

    pe_req_scheduler #(.NUM_REQ(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_instr(req_instr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .pe_instr(pe_instr), .pe_valid_in(pe_valid_in),
        .pe_result(pe_result), .pe_result_valid(pe_result_valid),
        .busy(busy), .err_timeout(err_timeout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] pe_fn(input logic [31:0] x);
        return (x == 32'h0210_8860) ? 32'd5 : ((x ^ 32'hA5A5_0000) + 32'd3);
    endfunction

    logic [31:0] instr_tab [4];
    assign req_instr = {instr_tab[3], instr_tab[2], instr_tab[1], instr_tab[0]};

    // ---------------- behavioural PE ----------------
    int unsigned lat;
    bit          mute;
    bit          stray;
    int unsigned pcnt;
    logic [31:0] held;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= 0;
            held <= '0;
        end else if (pe_valid_in && lat > 0) begin
            pcnt <= lat;
            held <= pe_instr;
        end else if (pcnt > 0) begin
            pcnt <= pcnt - 1;
        end
    end

    assign pe_result_valid = (!mute && ((lat == 0 && pe_valid_in) || pcnt == 1)) || stray;
    assign pe_result       = (lat == 0) ? pe_fn(pe_instr) : pe_fn(held);

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push_exp(input int id);
        exp_t e;
        e.id   = 2'(id);
        e.data = mute ? 32'hDEAD_BEEF : pe_fn(instr_tab[id]);
        e.err  = mute;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) chk("ready_outside_idle", 32'(req_ready), 32'd0);
            if (rsp_valid != 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << mon_e.id));
                    chk("rsp_id",    32'(rsp_id),    32'(mon_e.id));
                    chk("rsp_data",  rsp_data,       mon_e.data);
                    chk("rsp_err",   32'(err_timeout), 32'(mon_e.err));
                end
            end else begin
                chk("err_without_rsp", 32'(err_timeout), 32'd0);
            end
        end
    end

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- grant-order vectors ----------------
    typedef struct {
        logic [3:0]      valid;
        int unsigned     lat;
        int unsigned     n;
        logic [4:0][1:0] g;      // g[0] is the first expected grant
    } vec_t;

    vec_t vt [6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        logic [3:0] acc;

        vt[0] = '{4'b1111, 2, 5, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};  // rr -> 1
        vt[1] = '{4'b0100, 1, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd2}};  // rr -> 3
        vt[2] = '{4'b1010, 3, 2, {2'd0, 2'd0, 2'd0, 2'd1, 2'd3}};  // rr -> 2
        vt[3] = '{4'b0011, 0, 2, {2'd0, 2'd0, 2'd0, 2'd1, 2'd0}};  // rr -> 2
        vt[4] = '{4'b1000, 1, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd3}};  // rr wraps -> 0
        vt[5] = '{4'b0110, 2, 3, {2'd0, 2'd0, 2'd1, 2'd2, 2'd1}};  // rr -> 2

        instr_tab[0] = 32'h0210_8860;
        instr_tab[1] = 32'h1111_2222;
        instr_tab[2] = 32'h3C3C_0F0F;
        instr_tab[3] = 32'hCAFE_0042;

        rst_n = 1'b0; req_valid = '0; lat = 2; mute = 0; stray = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_req_ready", 32'(req_ready),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),   32'd0);
        chk("rst_rsp_data",  rsp_data,         32'd0);
        chk("rst_rsp_id",    32'(rsp_id),      32'd0);
        chk("rst_pe_instr",  pe_instr,         32'd0);
        chk("rst_pe_valid",  32'(pe_valid_in), 32'd0);
        chk("rst_err",       32'(err_timeout), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Table: grant order / fairness / wrap, with varying PE latency
        for (int r = 0; r < 6; r++) begin
            @(posedge clk); #1;
            lat = vt[r].lat;
            req_valid = vt[r].valid;
            k = 0; n = 0;
            while (k < int'(vt[r].n) && n < 300) begin
                @(negedge clk);
                n++;
                acc = req_valid & req_ready;
                if (acc != 4'b0000) begin
                    chk($sformatf("grant_r%0d_%0d", r, k), 32'(req_ready),
                        32'(4'b0001 << vt[r].g[k]));
                    push_exp(int'(vt[r].g[k]));
                    k++;
                    if (k == int'(vt[r].n)) begin
                        @(posedge clk); #1 req_valid = '0;
                    end
                end
            end
            chk($sformatf("grant_count_r%0d", r), 32'(k), vt[r].n);
            req_valid = '0;
            drain($sformatf("drain_r%0d", r));
        end

        // Req0 ADD with L=2: pulse at T+1, response at T+4
        @(posedge clk); #1 lat = 2; req_valid = 4'b0001;
        @(negedge clk);                                          // T
        chk("t1_ready", 32'(req_ready), 32'h1);
        push_exp(0);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);                                          // T+1
        chk("t1_pe_valid_t1", 32'(pe_valid_in), 32'd1);
        chk("t1_pe_instr",    pe_instr, 32'h0210_8860);
        @(negedge clk);                                          // T+2
        chk("t1_pe_valid_t2", 32'(pe_valid_in), 32'd0);
        chk("t1_pe_instr_held", pe_instr, 32'h0210_8860);
        @(negedge clk);                                          // T+3
        chk("t1_rsp_t3", 32'(rsp_valid), 32'd0);
        @(negedge clk);                                          // T+4
        chk("t1_rsp_t4",  32'(rsp_valid), 32'h1);
        chk("t1_data_t4", rsp_data, 32'd5);
        chk("t1_busy_t4", 32'(busy), 32'd0);
        drain("t1_drain");

        // Zero-latency PE: response at T+2; stray result in IDLE ignored
        @(posedge clk); #1 lat = 0; req_valid = 4'b0010;
        @(negedge clk);                                          // T
        chk("t4_ready", 32'(req_ready), 32'h2);
        push_exp(1);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);                                          // T+1
        chk("t4_rsp_t1", 32'(rsp_valid), 32'd0);
        @(negedge clk);                                          // T+2
        chk("t4_rsp_t2",  32'(rsp_valid), 32'h2);
        chk("t4_busy_t2", 32'(busy), 32'd0);
        drain("t4_drain");
        @(posedge clk); #1 stray = 1;
        @(negedge clk);
        chk("stray_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 stray = 0;
        repeat (2) begin
            @(negedge clk);
            chk("stray_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Reset during WAIT discards the op
        @(posedge clk); #1 lat = 20; req_valid = 4'b0100;
        @(negedge clk);
        chk("t5_ready", 32'(req_ready), 32'h4);
        push_exp(2);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(negedge clk);
        chk("t5_busy_wait", 32'(busy), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("t5_busy",      32'(busy),        32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid),   32'd0);
        chk("t5_pe_instr",  pe_instr,         32'd0);
        chk("t5_pe_valid",  32'(pe_valid_in), 32'd0);
        chk("t5_rsp_data",  rsp_data,         32'd0);
        chk("t5_rsp_id",    32'(rsp_id),      32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; lat = 1; req_valid = 4'b1000;
        @(negedge clk);
        chk("t5_after_ready", 32'(req_ready), 32'h8);
        push_exp(3);
        @(posedge clk); #1 req_valid = '0;
        drain("t5_drain");

`ifdef PE_SCHED_TIMEOUT_EN
        // PE never answers: abort response at T+10
        @(posedge clk); #1 lat = 2; mute = 1; req_valid = 4'b0001;
        @(negedge clk);                                          // T
        chk("t6_ready", 32'(req_ready), 32'h1);
        push_exp(0);
        @(posedge clk); #1 req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == 4'b0000 && n < 40);
        chk("t6_latency", 32'(n), 32'd10);
        chk("t6_err",     32'(err_timeout), 32'd1);
        chk("t6_data",    rsp_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t6_err_pulse", 32'(err_timeout), 32'd0);
        chk("t6_idle",      32'(busy), 32'd0);
        mute = 0;
        drain("t6_drain");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
